aes_decrypt_core: RTL and testbench
===================================

# aes_decrypt_core

Iterative AES-128 inverse cipher (FIPS-197 decryption) and the receive-side counterpart of the AES_top encryptor. It accepts one 128-bit ciphertext block and 128-bit cipher key per start and expands the key schedule internally. It then runs ten inverse rounds, one per clock, and presents the plaintext with a one-cycle valid strobe. It is driven with the same enable/data/key convention as the encryptor, so one bench can chain AES_top output into this block for round-trip checks.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10.
- AES_clk  input  1  single clock; all state updates on the rising edge.
- AES_rst  input  1  synchronous, active-high reset.
- AES_en  input  1  start request. Its rising edge (low on the previous clock, high now) starts a block. The level is ignored.
- AES_data_in  input  128  ciphertext. Bits [127:120] are state byte 0; columns are column-major per FIPS-197.
- AES_key_in  input  128  cipher key, same byte order.
- AES_data_out  output  128  plaintext. Holds its value until the next completion or reset.
- AES_data_out_valid  output  1  one-cycle pulse when AES_data_out is updated.
- AES_busy  output  1  high from the acceptance edge until the completion edge.

## Operation
- Registers:
  - en_d: previous AES_en.
  - fsm: IDLE, KEYEXP, ROUND.
  - rk[0..10]: round-key array.
  - state: 128-bit cipher state.
  - cnt: 4-bit counter.
- Start condition: fsm==IDLE && AES_en && !en_d. At that edge:
  - latch AES_data_in into state;
  - latch AES_key_in into rk[0];
  - cnt <= 1; fsm <= KEYEXP; busy <= 1.
- A rising edge of AES_en while busy is ignored and not queued. AES_data_in and AES_key_in are sampled only at the acceptance edge.
- KEYEXP, edges 1..10:
  - rk[cnt] <= forward key expansion of rk[cnt-1], using RotWord, SubWord and Rcon[cnt].
  - Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - On the cnt==10 edge, also state <= state ^ (newly computed rk10); cnt <= 9; fsm <= ROUND.
- ROUND, edges 11..19 (cnt 9 down to 1):
  - state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[cnt])).
  - cnt decrements.
- Final edge 20 (cnt==0):
  - AES_data_out <= InvSubBytes(InvShiftRows(state)) ^ rk[0], with no InvMixColumns;
  - AES_data_out_valid <= 1; busy <= 0; fsm <= IDLE.
- Arithmetic:
  - InvSubBytes is the inverse affine transform followed by multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1 (0 maps to 0). A 256-entry ROM is an equivalent implementation.
  - InvMixColumns uses the coefficients 0e,0b,0d,09, built from xtime chains.
  - The forward S-box is needed only for SubWord in the key schedule.
- en_d updates every cycle, including while busy. A start therefore requires AES_en to go low and return high after completion.

## Timing
- Reset values: AES_data_out=0, AES_data_out_valid=0, AES_busy=0, fsm=IDLE, en_d=0, cnt=0. rk and state are don't-care but are cleared.
- Latency: acceptance edge at T. AES_data_out_valid is high during the cycle after edge T+20, and AES_data_out is valid in that same cycle.
- AES_busy is high in the cycles after edges T..T+19.
- Throughput: one block per 21 cycles at best. The next rising edge of AES_en can be accepted at edge T+21 or later.
- AES_data_out_valid is high for exactly one cycle. It is never asserted without a preceding accepted start.
- Reset mid-operation: at the reset edge all outputs take their reset values and the block returns to IDLE. No valid pulse is produced for the aborted block.
- Reset asserted together with a rising edge of AES_en: reset wins and no start occurs. en_d is cleared to 0.
- The rising edge of AES_en on the first cycle after reset release is accepted if AES_en was low during reset. en_d is 0 after reset, so an AES_en held high through reset release is also accepted once.

## Test plan
- FIPS-197 C.1: key 00010203_04050607_08090a0b_0c0d0e0f, ct 69c4e0d8_6a7b0430_d8cdb780_70b4c55a → AES_data_out 00112233_44556677_8899aabb_ccddeeff, valid pulse exactly 20 cycles after acceptance, busy high for 20 cycles.
- FIPS-197 Appendix B: key 2b7e1516_28aed2a6_abf71588_09cf4f3c, ct 3925841d_02dc09fb_dc118597_196a0b32 → 3243f6a8_885a308d_313198a2_e0370734.
- Round trip with the encryptor:
  - Encrypt 000000e3_00000000_00000000_00000000 under key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc with AES_top.
  - Feed the resulting ciphertext and the same key here.
  - Output must equal the original plaintext.
- Held enable and busy re-trigger:
  - Hold AES_en high for 51 cycles → exactly one valid pulse.
  - Toggle AES_en low/high at T+5 with different data → ignored. The output still matches the first block, and no second pulse occurs.
- Mid-operation reset:
  - Assert AES_rst at T+12 for one cycle → data_out=0, valid and busy low, and no pulse appears afterwards.
  - A new start with vector C.1 then yields the correct result after 20 cycles.
- Back-to-back: drop AES_en at T+20 and raise it at T+21 with the Appendix B vector → accepted, and the second valid arrives at T+41.

Source files
------------

// File: rtl/aes_decrypt_core.sv
// ============================================================================
// aes_decrypt_core
// ----------------------------------------------------------------------------
// Iterative AES-128 inverse cipher (FIPS-197 decryption). A rising edge on
// AES_en while idle captures one ciphertext block and one cipher key. Over the
// next ten clocks the forward key schedule is expanded into rk[0..10]. The
// tenth of those clocks also applies the initial AddRoundKey with rk[10].
// Nine full inverse rounds follow, one per clock, and a final round without
// InvMixColumns produces the plaintext with a one-cycle valid strobe.
//
// Ports
//   AES_clk             in   1    clock, rising edge
//   AES_rst             in   1    synchronous active-high reset
//   AES_en              in   1    start request; only a 0->1 edge while idle
//                                 starts a block
//   AES_data_in         in   128  ciphertext, bits [127:120] = state byte 0,
//                                 column-major
//   AES_key_in          in   128  cipher key, same byte order
//   AES_data_out        out  128  plaintext, held until next completion/reset
//   AES_data_out_valid  out  1    one-cycle pulse when AES_data_out updates
//   AES_busy            out  1    high from acceptance until completion
//
// Latency: acceptance at edge T, AES_data_out_valid high after edge T+20.
// ============================================================================
module aes_decrypt_core (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);

    typedef enum logic [1:0] {
        IDLE,
        KEYEXP,
        ROUND
    } fsm_t;

    // ------------------------------------------------------------------------
    // GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1
    // ------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (= a^2 * a^4 * ... * a^128); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int k = 2; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    // Forward S-box: inverse then affine transform. Only SubWord uses it.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform, then multiplicative inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // InvShiftRows followed by InvSubBytes. Byte (r,c) sits at index r+4c;
    // row r is rotated right by r, so out(r,c) takes in(r,(c-r) mod 4).
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
            end
        end
        return res;
    endfunction

    // One InvMixColumns column: coefficients 0e,0b,0d,09 from xtime chains.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0]  a  [4];
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [7:0]  x2;
        logic [7:0]  x4;
        logic [7:0]  x8;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            res[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    fsm_t         fsm;
    fsm_t         fsm_next;
    logic         en_d;
    logic [127:0] rk [0:10];
    logic [127:0] state;
    logic [3:0]   cnt;

    // FSM decode strobes
    logic start;
    logic key_step;
    logic round_step;
    logic final_step;

    // Datapath results
    logic [3:0]   key_sel;
    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic [31:0]  sub_rot;
    logic [127:0] shift_sub;
    logic [127:0] round_out;
    logic [127:0] final_out;

    // ------------------------------------------------------------------------
    // Forward key expansion: rk[cnt] from rk[cnt-1]
    // ------------------------------------------------------------------------
    assign key_sel = cnt - 4'd1;

    always_comb begin
        prev_key = rk[key_sel];
        sub_rot  = {sbox(prev_key[23:16]), sbox(prev_key[15:8]),
                    sbox(prev_key[7:0]),   sbox(prev_key[31:24])};
        sub_rot[31:24] = sub_rot[31:24] ^ rcon(cnt);
        next_key[127:96] = prev_key[127:96] ^ sub_rot;
        next_key[95:64]  = prev_key[95:64]  ^ next_key[127:96];
        next_key[63:32]  = prev_key[63:32]  ^ next_key[95:64];
        next_key[31:0]   = prev_key[31:0]   ^ next_key[63:32];
    end

    // ------------------------------------------------------------------------
    // Inverse round datapath
    // ------------------------------------------------------------------------
    always_comb begin
        shift_sub = inv_shift_sub(state);
        round_out = inv_mix_columns(shift_sub ^ rk[cnt]);
        final_out = shift_sub ^ rk[0];
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge
    // values; blocking (=) is kept to combinational logic and functions.
    always_ff @(posedge AES_clk) begin
        if (AES_rst) fsm <= IDLE;
        else         fsm <= fsm_next;
    end

    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        fsm_next   = fsm;
        start      = 1'b0;
        key_step   = 1'b0;
        round_step = 1'b0;
        final_step = 1'b0;
        case (fsm)
            IDLE: begin
                if (AES_en && !en_d) begin
                    start    = 1'b1;
                    fsm_next = KEYEXP;
                end
            end
            KEYEXP: begin
                key_step = 1'b1;
                if (cnt == 4'd10) fsm_next = ROUND;
            end
            ROUND: begin
                if (cnt == 4'd0) begin
                    final_step = 1'b1;
                    fsm_next   = IDLE;
                end else begin
                    round_step = 1'b1;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            en_d               <= 1'b0;
            cnt                <= '0;
            state              <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
            AES_busy           <= 1'b0;
            // NOTE: the key array is cleared too so no key material from an
            // aborted block survives a reset.
            for (int i = 0; i <= 10; i++) rk[i] <= '0;
        end else begin
            en_d               <= AES_en;
            AES_data_out_valid <= 1'b0;

            if (start) begin
                state    <= AES_data_in;
                rk[0]    <= AES_key_in;
                cnt      <= 4'd1;
                AES_busy <= 1'b1;
            end

            if (key_step) begin
                rk[cnt] <= next_key;
                if (cnt == 4'd10) begin
                    // Initial AddRoundKey uses rk10 straight off the expander.
                    state <= state ^ next_key;
                    cnt   <= 4'd9;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end

            if (round_step) begin
                state <= round_out;
                cnt   <= cnt - 4'd1;
            end

            if (final_step) begin
                AES_data_out       <= final_out;
                AES_data_out_valid <= 1'b1;
                AES_busy           <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// ============================================================================
// tb_aes_decrypt_core
// ----------------------------------------------------------------------------
// Self-checking bench for aes_decrypt_core. A byte-array AES-128 encryptor
// built straight from FIPS-197 produces ciphertexts. Its S-box is
// derived by brute-force inverse search. The DUT must return the original
// plaintext. Known-answer vectors, timing, re-trigger, reset and back-to-back
// behaviour are covered by directed steps.
// ============================================================================
module tb_aes_decrypt_core;

    logic         AES_clk;
    logic         AES_rst;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;
    logic         AES_busy;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RT_KEY = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
    localparam logic [127:0] RT_PT  = 128'h000000e3000000000000000000000000;

    aes_decrypt_core dut (
        .AES_clk            (AES_clk),
        .AES_rst            (AES_rst),
        .AES_en             (AES_en),
        .AES_data_in        (AES_data_in),
        .AES_key_in         (AES_key_in),
        .AES_data_out       (AES_data_out),
        .AES_data_out_valid (AES_data_out_valid),
        .AES_busy           (AES_busy)
    );

    initial AES_clk = 1'b0;
    always #5 AES_clk = ~AES_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Reference model: FIPS-197 forward cipher on byte arrays
    // ------------------------------------------------------------------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = x;
        bb = y;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                     ^ inv[(i+7)%8] ^ c[i];
            end
            sbox[a] = s;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w   [44];
        logic [7:0]   st  [16];
        logic [7:0]   tmp [16];
        logic [7:0]   col [4];
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sbox[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    st[r+4*c] = tmp[r+4*((c+r)%4)];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) col[r] = st[4*c+r];
                    for (int r = 0; r < 4; r++)
                        st[4*c+r] = mul(8'h02, col[r]) ^ mul(8'h03, col[(r+1)%4])
                                  ^ col[(r+2)%4] ^ col[(r+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves AES_en low for one edge, then presents a block so that the next
    // rising clock edge (T) accepts it. Returns at the falling edge after T.
    task automatic start_block(input logic [127:0] ct, input logic [127:0] key);
        AES_en = 1'b0;
        @(negedge AES_clk);
        AES_data_in = ct;
        AES_key_in  = key;
        AES_en      = 1'b1;
        @(negedge AES_clk);
    endtask

    // Called at the falling edge after acceptance edge T. Waits (bounded) for
    // the valid pulse and checks data, latency, busy length and pulse width.
    task automatic finish_block(input string tag, input logic [127:0] exp);
        int n;
        int busy_n;
        bit got;
        n      = 0;
        busy_n = 0;
        got    = 1'b0;
        while (n <= 40 && !got) begin
            if (AES_data_out_valid) begin
                got = 1'b1;
            end else begin
                if (AES_busy) busy_n++;
                @(negedge AES_clk);
                n++;
            end
        end
        check({tag, "_valid_seen"}, 128'(got), 128'd1);
        if (got) begin
            check({tag, "_data"},      AES_data_out, exp);
            check({tag, "_latency"},   128'(n), 128'd20);
            check({tag, "_busy_len"},  128'(busy_n), 128'd20);
            check({tag, "_busy_done"}, 128'(AES_busy), 128'd0);
            @(negedge AES_clk);
            check({tag, "_pulse_one"}, 128'(AES_data_out_valid), 128'd0);
            check({tag, "_data_hold"}, AES_data_out, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed and randomized sequence
    // ------------------------------------------------------------------------
    initial begin
        int          pulses;
        int          busy_seen;
        logic [127:0] seen;
        logic [127:0] pt;
        logic [127:0] key;

        build_sbox();

        AES_rst     = 1'b1;
        AES_en      = 1'b0;
        AES_data_in = '0;
        AES_key_in  = '0;
        repeat (3) @(negedge AES_clk);
        check("rst_data",  AES_data_out, 128'd0);
        check("rst_valid", 128'(AES_data_out_valid), 128'd0);
        check("rst_busy",  128'(AES_busy), 128'd0);
        AES_rst = 1'b0;
        @(negedge AES_clk);

        // FIPS-197 C.1 and Appendix B known answers
        start_block(C1_CT, C1_KEY);
        check("c1_busy_start", 128'(AES_busy), 128'd1);
        finish_block("c1", C1_PT);
        start_block(B_CT, B_KEY);
        finish_block("appb", B_PT);

        // Round trip through the reference encryptor
        start_block(encrypt(RT_PT, RT_KEY), RT_KEY);
        finish_block("roundtrip", RT_PT);

        // AES_en held high for 51 cycles: exactly one block
        start_block(B_CT, B_KEY);
        pulses = 0;
        seen   = '0;
        for (int n = 0; n < 51; n++) begin
            if (AES_data_out_valid) begin
                pulses++;
                seen = AES_data_out;
            end
            @(negedge AES_clk);
        end
        check("held_pulses", 128'(pulses), 128'd1);
        check("held_data",   seen, B_PT);
        check("held_idle",   128'(AES_busy), 128'd0);

        // Re-trigger while busy with different data is ignored
        start_block(C1_CT, C1_KEY);
        pulses = 0;
        seen   = '0;
        for (int n = 0; n < 45; n++) begin
            if (n == 4) AES_en = 1'b0;
            if (n == 5) begin
                AES_en      = 1'b1;
                AES_data_in = B_CT;
                AES_key_in  = B_KEY;
            end
            if (AES_data_out_valid) begin
                pulses++;
                seen = AES_data_out;
            end
            @(negedge AES_clk);
        end
        check("retrig_pulses", 128'(pulses), 128'd1);
        check("retrig_data",   seen, C1_PT);
        check("retrig_hold",   AES_data_out, C1_PT);

        // Reset at T+12 aborts the block
        start_block(C1_CT, C1_KEY);
        repeat (11) @(negedge AES_clk);
        AES_rst = 1'b1;
        AES_en  = 1'b0;
        @(negedge AES_clk);
        check("midrst_data",  AES_data_out, 128'd0);
        check("midrst_valid", 128'(AES_data_out_valid), 128'd0);
        check("midrst_busy",  128'(AES_busy), 128'd0);
        AES_rst   = 1'b0;
        pulses    = 0;
        busy_seen = 0;
        for (int n = 0; n < 30; n++) begin
            if (AES_data_out_valid) pulses++;
            if (AES_busy) busy_seen++;
            @(negedge AES_clk);
        end
        check("midrst_no_pulse", 128'(pulses), 128'd0);
        check("midrst_no_busy",  128'(busy_seen), 128'd0);
        start_block(C1_CT, C1_KEY);
        finish_block("after_rst", C1_PT);

        // Reset coinciding with a rising AES_en wins; held enable is taken
        // once on release
        AES_en = 1'b0;
        @(negedge AES_clk);
        AES_rst     = 1'b1;
        AES_en      = 1'b1;
        AES_data_in = B_CT;
        AES_key_in  = B_KEY;
        @(negedge AES_clk);
        check("rst_rise_busy", 128'(AES_busy), 128'd0);
        AES_rst = 1'b0;
        @(negedge AES_clk);
        check("rel_busy", 128'(AES_busy), 128'd1);
        finish_block("rel", B_PT);

        // Back-to-back: low at edge T+20, high at T+21, second valid at T+41
        start_block(C1_CT, C1_KEY);
        repeat (19) @(negedge AES_clk);
        AES_en = 1'b0;
        @(negedge AES_clk);
        check("b2b_first_valid", 128'(AES_data_out_valid), 128'd1);
        check("b2b_first_data",  AES_data_out, C1_PT);
        AES_data_in = B_CT;
        AES_key_in  = B_KEY;
        AES_en      = 1'b1;
        @(negedge AES_clk);
        check("b2b_accept", 128'(AES_busy), 128'd1);
        finish_block("b2b_second", B_PT);

        // Randomized round trips
        for (int k = 0; k < 8; k++) begin
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_block(encrypt(pt, key), key);
            finish_block("rand", pt);
        end

        AES_en = 1'b0;
        repeat (2) @(negedge AES_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
